// File: rtl/variance_sqrt_ctrl.sv
// rtl/variance_sqrt_ctrl.sv - window variance to sqrt_mem index, root return as stddev
// Optional STDDEV_MIN_CLAMP_EN floors the returned root at MIN_STDDEV.
module variance_sqrt_ctrl #(
  parameter int W_SUM      = 18,
  parameter int W_SQSUM    = 26,
  parameter int AREA       = 576,
  parameter int SHIFT      = 12,
  parameter int W_ADDR     = 8,
  parameter int W_DATA     = 16,
  parameter int MIN_STDDEV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               win_valid,
  output logic               win_ready,
  input  logic [W_SUM-1:0]   win_sum,
  input  logic [W_SQSUM-1:0] win_sqsum,
  output logic               addr1_valid,
  input  logic               addr1_ready,
  output logic [W_ADDR-1:0]  addr1_data,
  input  logic               data1_valid,
  output logic               data1_ready,
  input  logic [W_DATA-1:0]  data1,
  output logic               stddev_valid,
  input  logic               stddev_ready,
  output logic [W_DATA-1:0]  stddev_data
);

  localparam int W_P1   = W_SQSUM + $clog2(AREA + 1);
  localparam int W_P0   = 2 * W_SUM;
  localparam int W_PMAX = (W_P1 > W_P0) ? W_P1 : W_P0;
  localparam int W_VAR  = W_PMAX + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_SUB,
    ST_ADDR,
    ST_WAIT,
    ST_OUT
  } state_e;

  state_e              state_q, state_d;
  logic [W_SUM-1:0]    sum_q, sum_d;
  logic [W_SQSUM-1:0]  sqsum_q, sqsum_d;
  logic [W_P1-1:0]     p1_q, p1_d;
  logic [W_P0-1:0]     p0_q, p0_d;
  logic [W_ADDR-1:0]   addr_q, addr_d;
  logic [W_DATA-1:0]   stddev_q, stddev_d;

  logic [W_VAR-1:0]    var_w;
  logic [W_VAR-1:0]    var_pos;
  logic [W_VAR-1:0]    idx_full;
  logic [W_ADDR-1:0]   idx_sat;
  logic [W_DATA-1:0]   root_w;

  // Both products are non-negative and fit in W_PMAX bits, so the extra bit is the sign.
  assign var_w    = W_VAR'(p1_q) - W_VAR'(p0_q);
  assign var_pos  = var_w[W_VAR-1] ? '0 : var_w;
  assign idx_full = var_pos >> SHIFT;
  assign idx_sat  = (idx_full > W_VAR'({W_ADDR{1'b1}})) ? {W_ADDR{1'b1}}
                                                       : idx_full[W_ADDR-1:0];

`ifdef STDDEV_MIN_CLAMP_EN
  localparam logic [W_DATA-1:0] MIN_SD = W_DATA'(MIN_STDDEV);
  assign root_w = (data1 < MIN_SD) ? MIN_SD : data1;
`else
  logic unused_min_stddev;
  assign unused_min_stddev = ^MIN_STDDEV;
  assign root_w = data1;
`endif

  assign addr1_data  = addr_q;
  assign stddev_data = stddev_q;

  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    sqsum_d      = sqsum_q;
    p1_d         = p1_q;
    p0_d         = p0_q;
    addr_d       = addr_q;
    stddev_d     = stddev_q;
    win_ready    = 1'b0;
    addr1_valid  = 1'b0;
    data1_ready  = 1'b0;
    stddev_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        win_ready = 1'b1;
        if (win_valid) begin
          sum_d   = win_sum;
          sqsum_d = win_sqsum;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        p1_d    = W_P1'(AREA) * W_P1'(sqsum_q);
        p0_d    = W_P0'(sum_q) * W_P0'(sum_q);
        state_d = ST_SUB;
      end
      ST_SUB: begin
        addr_d  = idx_sat;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        addr1_valid = 1'b1;
        if (addr1_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        data1_ready = 1'b1;
        if (data1_valid) begin
          stddev_d = root_w;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        stddev_valid = 1'b1;
        if (stddev_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sum_q    <= '0;
      sqsum_q  <= '0;
      p1_q     <= '0;
      p0_q     <= '0;
      addr_q   <= '0;
      stddev_q <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      sqsum_q  <= sqsum_d;
      p1_q     <= p1_d;
      p0_q     <= p0_d;
      addr_q   <= addr_d;
      stddev_q <= stddev_d;
    end
  end

endmodule

// File: tb/tb_variance_sqrt_ctrl.sv
// tb/tb_variance_sqrt_ctrl.sv - randomized self-checking bench for variance_sqrt_ctrl
// Reference: var = 576*sqsum - sum^2, floored at 0, index = var/4096 capped at 255.
module tb_variance_sqrt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        win_valid;
  logic        win_ready;
  logic [17:0] win_sum;
  logic [25:0] win_sqsum;
  logic        addr1_valid;
  logic        addr1_ready;
  logic [7:0]  addr1_data;
  logic        data1_valid;
  logic        data1_ready;
  logic [15:0] data1;
  logic        stddev_valid;
  logic        stddev_ready;
  logic [15:0] stddev_data;

  int n_chk    = 0;
  int n_fail   = 0;
  int emit_cnt = 0;
  logic [15:0] rom [256];

  variance_sqrt_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .win_sum      (win_sum),
    .win_sqsum    (win_sqsum),
    .addr1_valid  (addr1_valid),
    .addr1_ready  (addr1_ready),
    .addr1_data   (addr1_data),
    .data1_valid  (data1_valid),
    .data1_ready  (data1_ready),
    .data1        (data1),
    .stddev_valid (stddev_valid),
    .stddev_ready (stddev_ready),
    .stddev_data  (stddev_data)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; 2 time units later they are stable until the next rise.
  always begin
    @(negedge clk);
    #2;
    if (!rst && stddev_valid && stddev_ready) emit_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int ref_idx(input longint s, input longint sq);
    longint v;
    v = 576 * sq - s * s;
    if (v < 0) v = 0;
    v = v / 4096;
    if (v > 255) v = 255;
    return int'(v);
  endfunction

  function automatic logic [15:0] ref_sd(input logic [15:0] r);
`ifdef STDDEV_MIN_CLAMP_EN
    return (r < 16'd1) ? 16'd1 : r;
`else
    return r;
`endif
  endfunction

  task automatic run_window(input string nm, input longint s, input longint sq,
                            input int a_stall, input int o_stall, input bit chk_lat);
    int eidx;
    int cyc;
    logic [15:0] esd;
    logic [7:0]  a_seen;
    eidx = ref_idx(s, sq);
    esd  = ref_sd(rom[eidx]);
    @(negedge clk);
    n_chk++; if (win_ready !== 1'b1) begin n_fail++; $display("FAIL %s win_ready_idle got %0b want 1", nm, win_ready); end
    win_valid    = 1'b1;
    win_sum      = s[17:0];
    win_sqsum    = sq[25:0];
    addr1_ready  = (a_stall == 0);
    stddev_ready = (o_stall == 0);
    @(negedge clk);
    win_valid = 1'b0;
    cyc = 1;
    n_chk++; if (win_ready !== 1'b0) begin n_fail++; $display("FAIL %s win_ready_busy got %0b want 0", nm, win_ready); end
    while (addr1_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    n_chk++; if (addr1_valid !== 1'b1) begin n_fail++; $display("FAIL %s addr_timeout got %0b want 1", nm, addr1_valid); end
    if (chk_lat) begin
      n_chk++; if (cyc != 3) begin n_fail++; $display("FAIL %s addr_latency got %0d want 3", nm, cyc); end
    end
    n_chk++; if (addr1_data !== 8'(eidx)) begin n_fail++; $display("FAIL %s addr1_data got %0d want %0d", nm, addr1_data, eidx); end
    for (int k = 0; k < a_stall; k++) begin
      @(negedge clk); cyc++;
      n_chk++;
      if (addr1_valid !== 1'b1 || addr1_data !== 8'(eidx) || win_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s addr_hold v=%0b a=%0d wr=%0b want 1/%0d/0", nm, addr1_valid, addr1_data, win_ready, eidx);
      end
    end
    addr1_ready = 1'b1;
    a_seen = addr1_data;
    @(negedge clk); cyc++;
    n_chk++; if (data1_ready !== 1'b1) begin n_fail++; $display("FAIL %s data1_ready got %0b want 1", nm, data1_ready); end
    data1_valid = 1'b1;
    data1       = rom[a_seen];
    @(negedge clk); cyc++;
    data1_valid = 1'b0;
    data1       = 16'($urandom);
    n_chk++; if (stddev_valid !== 1'b1 || stddev_data !== esd) begin
      n_fail++; $display("FAIL %s stddev got v=%0b d=%h want v=1 d=%h", nm, stddev_valid, stddev_data, esd);
    end
    if (chk_lat) begin
      n_chk++; if (cyc != 5) begin n_fail++; $display("FAIL %s stddev_latency got %0d want 5", nm, cyc); end
    end
    for (int k = 0; k < o_stall; k++) begin
      @(negedge clk); cyc++;
      n_chk++;
      if (stddev_valid !== 1'b1 || stddev_data !== esd || win_ready !== 1'b0 || addr1_data !== 8'(eidx)) begin
        n_fail++; $display("FAIL %s out_hold v=%0b d=%h wr=%0b want 1/%h/0", nm, stddev_valid, stddev_data, win_ready, esd);
      end
    end
    stddev_ready = 1'b1;
    @(negedge clk); cyc++;
    n_chk++; if (stddev_valid !== 1'b0 || win_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s back_to_idle v=%0b wr=%0b want 0/1", nm, stddev_valid, win_ready);
    end
    if (chk_lat) begin
      n_chk++; if (cyc != 6) begin n_fail++; $display("FAIL %s next_ready_latency got %0d want 6", nm, cyc); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (win_ready !== 1'b1) begin n_fail++; $display("FAIL reset win_ready got %0b want 1", win_ready); end
    n_chk++; if ({addr1_valid, data1_ready, stddev_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset valids got %b want 000", {addr1_valid, data1_ready, stddev_valid});
    end
    n_chk++; if (addr1_data !== 8'd0 || stddev_data !== 16'd0) begin
      n_fail++; $display("FAIL reset data got a=%0d s=%h want 0/0", addr1_data, stddev_data);
    end
  endtask

  task automatic test_flat;
    run_window("flat", 5760, 57600, 0, 0, 1'b1);
  endtask

  task automatic test_mid;
    run_window("mid", 0, 1000, 0, 0, 1'b1);
  endtask

  task automatic test_saturation;
    run_window("saturate", 0, 10000, 0, 0, 1'b1);
  endtask

  task automatic test_negative;
    run_window("negative", 100, 0, 0, 0, 1'b1);
  endtask

  task automatic test_backpressure;
    int e0;
    e0 = emit_cnt;
    run_window("backpressure", 0, 1000, 5, 4, 1'b0);
    repeat (3) @(negedge clk);
    n_chk++; if (emit_cnt != e0 + 1) begin n_fail++; $display("FAIL backpressure emit_count got %0d want %0d", emit_cnt - e0, 1); end
  endtask

  task automatic test_reset_in_wait;
    int e0;
    bit saw_valid;
    e0 = emit_cnt;
    saw_valid = 1'b0;
    @(negedge clk);
    win_valid    = 1'b1;
    win_sum      = 18'd0;
    win_sqsum    = 26'd1000;
    addr1_ready  = 1'b1;
    stddev_ready = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (data1_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait in_wait got %0b want 1", data1_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (win_ready !== 1'b1 || data1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait after_release wr=%0b dr=%0b want 1/0", win_ready, data1_ready);
    end
    n_chk++; if (addr1_data !== 8'd0 || stddev_data !== 16'd0) begin
      n_fail++; $display("FAIL rst_wait data a=%0d s=%h want 0/0", addr1_data, stddev_data);
    end
    data1_valid = 1'b1;
    data1       = 16'h1234;
    repeat (6) begin
      @(negedge clk);
      if (stddev_valid !== 1'b0) saw_valid = 1'b1;
    end
    data1_valid = 1'b0;
    n_chk++; if (saw_valid) begin n_fail++; $display("FAIL rst_wait late_data stddev_valid got 1 want 0"); end
    n_chk++; if (emit_cnt != e0) begin n_fail++; $display("FAIL rst_wait emit_count got %0d want 0", emit_cnt - e0); end
    n_chk++; if (win_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait win_ready got %0b want 1", win_ready); end
    run_window("post_reset", 0, 1000, 0, 0, 1'b1);
  endtask

  task automatic test_back_to_back;
    longint s;
    longint sq;
    int e0;
    e0 = emit_cnt;
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: begin
          s  = longint'($urandom_range(0, 262143));
          sq = longint'($urandom_range(0, 67108863));
        end
        1: begin
          s  = longint'($urandom_range(0, 150000));
          sq = (s * s) / 576 + longint'($urandom_range(0, 2000));
        end
        default: begin
          s  = longint'($urandom_range(0, 4000));
          sq = longint'($urandom_range(0, 2000));
        end
      endcase
      run_window("random", s, sq, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end
    repeat (2) @(negedge clk);
    n_chk++; if (emit_cnt != e0 + 24) begin n_fail++; $display("FAIL back_to_back emit_count got %0d want 24", emit_cnt - e0); end
  endtask

  initial begin
    rst          = 1'b1;
    win_valid    = 1'b0;
    win_sum      = '0;
    win_sqsum    = '0;
    addr1_ready  = 1'b1;
    data1_valid  = 1'b0;
    data1        = '0;
    stddev_ready = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[0]   = 16'h0000;
    rom[140] = 16'h0BB8;
    test_reset;
    test_flat;
    test_mid;
    test_saturation;
    test_negative;
    test_backpressure;
    test_reset_in_wait;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
